p16_uart_fifo_fwft: RTL and testbench
=====================================

Name: p16_uart_fifo_fwft

Overview:
Next-generation UART byte/frame buffer. A parametrised, first-word-fall-through (FWFT) FIFO placed between the UART RX/TX engines and the text-processing core.
- Head word is presented with o_rd_valid whenever the FIFO is non-empty; a pop consumes it.
- Adds a ready handshake, an occupancy count, almost-empty/almost-full thresholds, synchronous flush, and sticky overflow/underflow error flags.
- Over- and under-runs are dropped safely, never corrupting state.

Parameters:
- WIDTH, 9, data word width in bits (8 data bits plus 1 flag bit).
- DEPTH, 128, total capacity in words; power of two, >= 4.
- ALMOST_FULL, 100, o_almostfull asserts when count >= ALMOST_FULL; range 1..DEPTH.
- ALMOST_EMPTY, 4, o_almostempty asserts when count <= ALMOST_EMPTY; range 0..DEPTH-1.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_flush  in  1  synchronous flush; discards all contents
- i_wr_en  in  1  push request
- i_wr_data  in  WIDTH  push data
- o_wr_ready  out  1  FIFO can accept a push this cycle (= ~o_full)
- i_rd_en  in  1  pop request for the head word
- o_rd_data  out  WIDTH  head word; meaningful only while o_rd_valid
- o_rd_valid  out  1  head word present (= ~o_empty)
- o_count  out  $clog2(DEPTH)+1  words held
- o_empty, o_full, o_almostfull, o_almostempty  out  1 each  status
- o_overflow  out  1  sticky: push attempted while full
- o_underflow  out  1  sticky: pop attempted while empty
- i_clr_err  in  1  clears both sticky flags

Behaviour:
- Reset (i_rst_n low, async assert, sync release): pointers=0, count=0, o_rd_data=0, both sticky flags=0.
  - Resulting outputs: o_rd_valid=0, o_empty=1, o_almostempty=1, o_full=0, o_wr_ready=1.
  - Storage array is not reset.
- All status outputs decode combinationally from the registered count:
  - empty: count==0
  - full: count==DEPTH
  - almostfull: count>=ALMOST_FULL
  - almostempty: count<=ALMOST_EMPTY
- Push accepted iff i_wr_en && ~o_full, judged on the count at the start of the cycle.
- Pop accepted iff i_rd_en && o_rd_valid.
- Count update: accepted push only -> +1; accepted pop only -> -1; both or neither -> unchanged. Count never exceeds DEPTH and never goes below 0.
- FWFT latency:
  - A push into an empty FIFO at edge t gives o_rd_valid=1 with o_rd_data=that word after edge t (bypass path; no extra cycle).
  - An accepted pop at edge t presents the next word after edge t, or drops o_rd_valid if count becomes 0.
  - o_rd_data is stable while o_rd_valid is high and no pop occurs.
- Simultaneous push+pop:
  - count==1: head is replaced by the new word; o_rd_valid stays 1.
  - count==0: push accepted, pop ignored, underflow set.
  - count==DEPTH: pop accepted, push dropped, overflow set; count becomes DEPTH-1.
- Rejected push: data discarded, no pointer move, o_overflow<=1. Rejected pop: no state change, o_underflow<=1.
- Pointers wrap modulo DEPTH naturally; no special case at the wrap boundary.
- i_flush: next cycle count=0 and pointers=0. Flush overrides any same-cycle push/pop, which are ignored and raise no error flags. Sticky flags are not cleared by flush.
- i_clr_err: clears both flags next cycle. A new error in the same cycle wins, so the flag stays 1.
- Reset asserted mid-operation: immediate return to reset state; in-flight push/pop is lost.

Decomposition:
- Package p16_uart_pkg holds:
  - localparam default WIDTH/DEPTH;
  - typedef p16_fifo_status_t, a packed struct of empty, full, almostfull, almostempty, overflow, underflow, for upstream status muxing;
  - a helper function computing the count width.
- Sub-module p16_fifo_ram: DEPTH x WIDTH storage, synchronous write, combinational read, no reset. Pointer, count, bypass and flag logic stay in the top module.

Test Plan:
- Reset then push 0x041 once -> after that edge o_rd_valid=1, o_rd_data=0x041, o_count=1, o_almostempty=1; pop -> o_rd_valid=0, o_count=0.
- Push 128 words 0..127 with no pops -> o_almostfull rises at count=100, o_full=1 and o_wr_ready=0 at 128; 129th push of 0x1FF dropped, o_overflow=1, count stays 128; pop all 128 -> data 0..127 in order, crossing pointer wrap.
- Fill 128, then push+pop together -> pop returns 0, push dropped, overflow=1, count=127.
- Count=1 (head 0x0AA): push 0x0BB and pop together -> next cycle o_rd_data=0x0BB, o_rd_valid=1, count=1. Empty: push 0x0CC and pop together -> count=1, head 0x0CC, o_underflow=1.
- Count=50, assert i_flush with a push -> next cycle count=0, empty=1, no flags set. Then i_clr_err coincident with an illegal pop -> o_underflow remains 1.
- Count=37, drop i_rst_n asynchronously between edges -> outputs take reset values immediately, without waiting for a clock edge. Release, push 0x055 -> head 0x055, count=1.

Source files
------------

// File: rtl/p16_uart_pkg.sv
// rtl/p16_uart_pkg.sv - shared defaults, status struct and sizing helper for the UART FWFT FIFO
// Contents:
//   P16_WIDTH, P16_DEPTH  default word width and depth
//   p16_fifo_status_t     packed status bundle for upstream status muxing
//   p16_cnt_w()           width of an occupancy count able to hold 0..depth
package p16_uart_pkg;

  localparam int P16_WIDTH = 9;
  localparam int P16_DEPTH = 128;

  typedef struct packed {
    logic empty;
    logic full;
    logic almostfull;
    logic almostempty;
    logic overflow;
    logic underflow;
  } p16_fifo_status_t;

  function automatic int p16_cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/p16_fifo_ram.sv
// rtl/p16_fifo_ram.sv - DEPTH x WIDTH storage, synchronous write, combinational read
// Ports:
//   i_clk    clock
//   i_we     write enable
//   i_waddr  write address
//   i_wdata  write data
//   i_raddr  read address
//   o_rdata  read data (combinational)
module p16_fifo_ram #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 128,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  // No reset: contents are only ever read after being written.
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = mem[i_raddr];

endmodule

// File: rtl/p16_uart_fifo_fwft.sv
// rtl/p16_uart_fifo_fwft.sv - first-word-fall-through FIFO between the UART engines and the text core
// Ports:
//   i_clk, i_rst_n              clock, asynchronous active-low reset
//   i_flush                     synchronous discard of all contents
//   i_wr_en, i_wr_data          push request and data; o_wr_ready = ~o_full
//   i_rd_en                     pop of the head word
//   o_rd_data, o_rd_valid       registered head word and its valid (= ~o_empty)
//   o_count                     words held
//   o_empty, o_full, o_almostfull, o_almostempty   status decoded from o_count
//   o_overflow, o_underflow     sticky error flags, cleared by i_clr_err
module p16_uart_fifo_fwft
  import p16_uart_pkg::*;
#(
  parameter int WIDTH        = P16_WIDTH,
  parameter int DEPTH        = P16_DEPTH,
  parameter int ALMOST_FULL  = 100,
  parameter int ALMOST_EMPTY = 4,
  localparam int AW          = $clog2(DEPTH),
  localparam int CW          = p16_cnt_w(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_flush,
  input  logic             i_wr_en,
  input  logic [WIDTH-1:0] i_wr_data,
  output logic             o_wr_ready,
  input  logic             i_rd_en,
  output logic [WIDTH-1:0] o_rd_data,
  output logic             o_rd_valid,
  output logic [CW-1:0]    o_count,
  output logic             o_empty,
  output logic             o_full,
  output logic             o_almostfull,
  output logic             o_almostempty,
  output logic             o_overflow,
  output logic             o_underflow,
  input  logic             i_clr_err
);

  logic [AW-1:0]    wr_ptr, rd_ptr, rd_ptr_inc;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] head;
  logic [WIDTH-1:0] ram_next;
  logic             ovf, unf;
  logic             push_ok, pop_ok, ovf_evt, unf_evt;
  p16_fifo_status_t st;

  always_comb begin
    st             = '0;
    st.empty       = (count == '0);
    st.full        = (count == CW'(DEPTH));
    st.almostfull  = (count >= CW'(ALMOST_FULL));
    st.almostempty = (count <= CW'(ALMOST_EMPTY));
    st.overflow    = ovf;
    st.underflow   = unf;
  end

  // Flush swallows any same-cycle push/pop, including their error events.
  assign push_ok    = i_wr_en && !st.full  && !i_flush;
  assign pop_ok     = i_rd_en && !st.empty && !i_flush;
  assign ovf_evt    = i_wr_en &&  st.full  && !i_flush;
  assign unf_evt    = i_rd_en &&  st.empty && !i_flush;
  assign rd_ptr_inc = rd_ptr + AW'(1);

  p16_fifo_ram #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_ram (
    .i_clk   (i_clk),
    .i_we    (push_ok),
    .i_waddr (wr_ptr),
    .i_wdata (i_wr_data),
    .i_raddr (rd_ptr_inc),
    .o_rdata (ram_next)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      head   <= '0;
      ovf    <= 1'b0;
      unf    <= 1'b0;
    end else begin
      if (i_flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push_ok) wr_ptr <= wr_ptr + AW'(1);
        if (pop_ok)  rd_ptr <= rd_ptr_inc;
        if (push_ok && !pop_ok)      count <= count + CW'(1);
        else if (pop_ok && !push_ok) count <= count - CW'(1);

        // Head register: with a single word held, the successor is the word
        // being pushed right now (not yet in RAM), so it is bypassed in.
        if (pop_ok) begin
          if (count == CW'(1)) begin
            if (push_ok) head <= i_wr_data;
          end else begin
            head <= ram_next;
          end
        end else if (push_ok && st.empty) begin
          head <= i_wr_data;
        end
      end

      // A new error outranks a same-cycle clear.
      if (ovf_evt)        ovf <= 1'b1;
      else if (i_clr_err) ovf <= 1'b0;
      if (unf_evt)        unf <= 1'b1;
      else if (i_clr_err) unf <= 1'b0;
    end
  end

  assign o_count       = count;
  assign o_rd_data     = head;
  assign o_rd_valid    = !st.empty;
  assign o_wr_ready    = !st.full;
  assign o_empty       = st.empty;
  assign o_full        = st.full;
  assign o_almostfull  = st.almostfull;
  assign o_almostempty = st.almostempty;
  assign o_overflow    = st.overflow;
  assign o_underflow   = st.underflow;

endmodule

// File: tb/tb_p16_uart_fifo_fwft.sv
// tb/tb_p16_uart_fifo_fwft.sv - queue-model self-checking bench for p16_uart_fifo_fwft
`timescale 1ns/1ps
module tb_p16_uart_fifo_fwft;

  localparam int DEPTH = 128;
  localparam int AF    = 100;
  localparam int AE    = 4;

  logic       i_clk = 1'b0;
  logic       i_rst_n = 1'b0;
  logic       i_flush = 1'b0;
  logic       i_wr_en = 1'b0;
  logic [8:0] i_wr_data = '0;
  logic       i_rd_en = 1'b0;
  logic       i_clr_err = 1'b0;
  logic       o_wr_ready, o_rd_valid, o_empty, o_full, o_almostfull, o_almostempty;
  logic       o_overflow, o_underflow;
  logic [8:0] o_rd_data;
  logic [7:0] o_count;

  p16_uart_fifo_fwft dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_flush(i_flush),
    .i_wr_en(i_wr_en), .i_wr_data(i_wr_data), .o_wr_ready(o_wr_ready),
    .i_rd_en(i_rd_en), .o_rd_data(o_rd_data), .o_rd_valid(o_rd_valid),
    .o_count(o_count), .o_empty(o_empty), .o_full(o_full),
    .o_almostfull(o_almostfull), .o_almostempty(o_almostempty),
    .o_overflow(o_overflow), .o_underflow(o_underflow), .i_clr_err(i_clr_err)
  );

  always #5 i_clk = ~i_clk;

  int passed = 0;
  int total  = 0;
  bit chk_en = 0;

  // Reference model: contents as a queue, plus two sticky bits.
  int m_q[$];
  bit m_ovf = 0;
  bit m_unf = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_q.delete();
    m_ovf = 0;
    m_unf = 0;
  endtask

  // Called right at a rising edge, using the inputs held across that edge.
  task automatic model_step();
    int  n;
    bit  p, q;
    if (!i_rst_n) return;
    n = m_q.size();
    if (i_flush) begin
      m_q.delete();
      if (i_clr_err) begin m_ovf = 0; m_unf = 0; end
    end else begin
      p = i_wr_en && (n < DEPTH);
      q = i_rd_en && (n > 0);
      if (q) void'(m_q.pop_front());
      if (p) m_q.push_back(int'(i_wr_data));
      if (i_wr_en && n == DEPTH) m_ovf = 1; else if (i_clr_err) m_ovf = 0;
      if (i_rd_en && n == 0)     m_unf = 1; else if (i_clr_err) m_unf = 0;
    end
  endtask

  // Compare process: every falling edge once enabled.
  always @(negedge i_clk) begin
    if (chk_en && i_rst_n) begin
      int n;
      n = m_q.size();
      chk("count",       int'(o_count),       n);
      chk("rd_valid",    int'(o_rd_valid),    int'(n > 0));
      chk("empty",       int'(o_empty),       int'(n == 0));
      chk("full",        int'(o_full),        int'(n == DEPTH));
      chk("wr_ready",    int'(o_wr_ready),    int'(n != DEPTH));
      chk("almostfull",  int'(o_almostfull),  int'(n >= AF));
      chk("almostempty", int'(o_almostempty), int'(n <= AE));
      chk("overflow",    int'(o_overflow),    int'(m_ovf));
      chk("underflow",   int'(o_underflow),   int'(m_unf));
      if (n > 0) chk("rd_data", int'(o_rd_data), m_q[0]);
    end
  end

  task automatic cyc(input bit wr, input int wd, input bit rd, input bit fl, input bit clr);
    i_wr_en   = wr;
    i_wr_data = 9'(wd);
    i_rd_en   = rd;
    i_flush   = fl;
    i_clr_err = clr;
    @(posedge i_clk);
    model_step();
    #1;
    i_wr_en = 0; i_rd_en = 0; i_flush = 0; i_clr_err = 0;
  endtask

  initial begin
    model_reset();
    repeat (3) @(posedge i_clk);
    #1 i_rst_n = 1'b1;
    chk("rst_valid", int'(o_rd_valid), 0);
    chk("rst_empty", int'(o_empty), 1);
    chk("rst_ae",    int'(o_almostempty), 1);
    chk("rst_full",  int'(o_full), 0);
    chk("rst_ready", int'(o_wr_ready), 1);
    chk("rst_count", int'(o_count), 0);
    chk("rst_data",  int'(o_rd_data), 0);
    chk("rst_flags", int'({o_overflow, o_underflow}), 0);
    chk_en = 1;

    // Single push / pop latency.
    cyc(1, 'h041, 0, 0, 0);
    chk("t1_valid", int'(o_rd_valid), 1);
    chk("t1_data",  int'(o_rd_data), 'h041);
    chk("t1_count", int'(o_count), 1);
    chk("t1_ae",    int'(o_almostempty), 1);
    cyc(0, 0, 1, 0, 0);
    chk("t1_pop_valid", int'(o_rd_valid), 0);
    chk("t1_pop_count", int'(o_count), 0);

    // Fill to full, overflow, drain across the pointer wrap.
    for (int i = 0; i < 128; i++) begin
      cyc(1, i, 0, 0, 0);
      if (i == 98) chk("af_at99",  int'(o_almostfull), 0);
      if (i == 99) chk("af_at100", int'(o_almostfull), 1);
    end
    chk("fill_full",  int'(o_full), 1);
    chk("fill_ready", int'(o_wr_ready), 0);
    cyc(1, 'h1FF, 0, 0, 0);
    chk("ovf_flag",  int'(o_overflow), 1);
    chk("ovf_count", int'(o_count), 128);
    for (int i = 0; i < 128; i++) begin
      chk("drain_data", int'(o_rd_data), i);
      cyc(0, 0, 1, 0, 0);
    end
    chk("drain_empty", int'(o_empty), 1);

    // Full with simultaneous push+pop.
    cyc(0, 0, 0, 0, 1);
    for (int i = 0; i < 128; i++) cyc(1, i, 0, 0, 0);
    chk("fpp_head", int'(o_rd_data), 0);
    cyc(1, 'h1EE, 1, 0, 0);
    chk("fpp_count", int'(o_count), 127);
    chk("fpp_ovf",   int'(o_overflow), 1);
    chk("fpp_head2", int'(o_rd_data), 1);
    cyc(0, 0, 0, 1, 1);

    // Head replacement at count 1, push+pop on empty.
    cyc(1, 'h0AA, 0, 0, 0);
    cyc(1, 'h0BB, 1, 0, 0);
    chk("c1_data",  int'(o_rd_data), 'h0BB);
    chk("c1_valid", int'(o_rd_valid), 1);
    chk("c1_count", int'(o_count), 1);
    cyc(0, 0, 1, 0, 0);
    cyc(1, 'h0CC, 1, 0, 0);
    chk("c0_count", int'(o_count), 1);
    chk("c0_data",  int'(o_rd_data), 'h0CC);
    chk("c0_unf",   int'(o_underflow), 1);

    // Flush with a push, then clear racing a new underflow.
    cyc(0, 0, 0, 1, 1);
    chk("clr_flags", int'({o_overflow, o_underflow}), 0);
    for (int i = 0; i < 50; i++) cyc(1, i + 7, 0, 0, 0);
    cyc(1, 'h123, 0, 1, 0);
    chk("fl_count", int'(o_count), 0);
    chk("fl_empty", int'(o_empty), 1);
    chk("fl_flags", int'({o_overflow, o_underflow}), 0);
    cyc(0, 0, 1, 0, 1);
    chk("clr_vs_unf", int'(o_underflow), 1);

    // Asynchronous reset between edges.
    cyc(0, 0, 0, 0, 1);
    for (int i = 0; i < 37; i++) cyc(1, i + 3, 0, 0, 0);
    #1 i_rst_n = 1'b0;
    model_reset();
    #1;
    chk("arst_count", int'(o_count), 0);
    chk("arst_valid", int'(o_rd_valid), 0);
    chk("arst_empty", int'(o_empty), 1);
    chk("arst_data",  int'(o_rd_data), 0);
    @(posedge i_clk);
    #1 i_rst_n = 1'b1;
    cyc(1, 'h055, 0, 0, 0);
    chk("arst_head",  int'(o_rd_data), 'h055);
    chk("arst_cnt1",  int'(o_count), 1);

    // Randomized traffic with drifting fill bias.
    for (int c = 0; c < 4000; c++) begin
      int wp, rp;
      wp = ((c / 400) % 2 == 0) ? 75 : 25;
      rp = 100 - wp;
      cyc($urandom_range(0, 99) < wp, int'($urandom_range(0, 511)),
          $urandom_range(0, 99) < rp,
          $urandom_range(0, 199) == 0,
          $urandom_range(0, 63) == 0);
    end

    @(negedge i_clk);
    chk_en = 0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
